// File: rtl/dram_ctrl_if.sv
// -----------------------------------------------------------------------------
// dram_ctrl_if
//   Host-side request/response bundle between the system bus and dram_ctrl.
//
//   Request  : req_valid, req_ready, req_we, req_be, req_addr, req_wdata
//   Response : rd_valid (1-cycle pulse), rd_data (held until next read)
//   Status   : busy (controller FSM not idle)
//
//   Modports
//     master : the host, drives the request fields
//     slave  : dram_ctrl, drives ready/response/status
// -----------------------------------------------------------------------------
interface dram_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_be;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              busy;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata,
        input  req_ready, rd_valid, rd_data, busy
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata,
        output req_ready, rd_valid, rd_data, busy
    );
endinterface

// File: rtl/dram_ctrl.sv
// -----------------------------------------------------------------------------
// dram_ctrl
//   Synchronous host-side controller for an asynchronous RAS/CAS DRAM.
//   Turns single-word host requests into full or byte-masked write cycles and
//   read cycles, and (optionally) issues periodic CAS-before-RAS refresh.
//
//   Ports
//     CLK, RST             : clock, asynchronous active-high reset
//     bus (slave modport)  : host request/response handshake (dram_ctrl_if)
//     RAS_N, CAS_N         : row/column strobes, registered
//     LWE_N, UWE_N         : lower/upper byte write enables, registered
//     OE_N                 : output enable for reads, registered
//     MA                   : DRAM address, registered
//     DATA                 : bidirectional data, driven only during writes
//
//   Build option
//     DRAM_CTRL_REFRESH_EN : when defined, a refresh interval counter and the
//                            REF_CAS/REF_RAS/REF_OFF states are built; when
//                            undefined the controller never refreshes and
//                            req_ready is simply "FSM in IDLE".
//
//   DATA_W must be 16 (two byte lanes, be[0] -> [7:0], be[1] -> [15:8]).
// -----------------------------------------------------------------------------
module dram_ctrl #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 16,
    parameter int T_RCD        = 1,
    parameter int T_CAS        = 2,
    parameter int T_RP         = 1,
    parameter int REF_INTERVAL = 64
) (
    input  logic              CLK,
    input  logic              RST,
    dram_ctrl_if.slave        bus,
    output logic              RAS_N,
    output logic              CAS_N,
    output logic              LWE_N,
    output logic              UWE_N,
    output logic              OE_N,
    output logic [ADDR_W-1:0] MA,
    inout  wire  [DATA_W-1:0] DATA
);

    // Elaboration-time parameter sanity.
    if (DATA_W != 16) begin : g_bad_data_w
        $error("dram_ctrl: DATA_W must be 16");
    end
    if (T_RCD < 1 || T_CAS < 1 || T_RP < 1) begin : g_bad_timing
        $error("dram_ctrl: T_RCD, T_CAS and T_RP must be at least 1");
    end
    if (REF_INTERVAL < 8) begin : g_bad_ref
        $error("dram_ctrl: REF_INTERVAL must be at least 8");
    end

    // One shared phase counter covers the longest of the three timed phases.
    localparam int T_MAX1 = (T_RCD > T_CAS) ? T_RCD : T_CAS;
    localparam int T_MAX  = (T_MAX1 > T_RP) ? T_MAX1 : T_RP;
    localparam int CNT_W  = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ROW,
        COL,
        CAS_OFF,
`ifdef DRAM_CTRL_REFRESH_EN
        PRE,
        REF_CAS,
        REF_RAS,
        REF_OFF
`else
        PRE
`endif
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;

    // Request fields captured at the handshake.
    logic              we_q;
    logic [1:0]        be_q;
    logic [DATA_W-1:0] wdata_q;

    logic              data_oe;
    logic              rd_valid_r;
    logic [DATA_W-1:0] rd_data_r;

    assign DATA         = data_oe ? wdata_q : {DATA_W{1'bz}};
    assign bus.rd_valid = rd_valid_r;
    assign bus.rd_data  = rd_data_r;
    assign bus.busy     = (state != IDLE);

`ifdef DRAM_CTRL_REFRESH_EN
    localparam int               REF_W      = $clog2(REF_INTERVAL);
    localparam logic [REF_W-1:0] REF_RELOAD = REF_W'(REF_INTERVAL - 1);

    logic [REF_W-1:0] ref_cnt;
    logic             ref_pending;
    logic             ref_take;

    // The FSM leaves IDLE for REF_CAS exactly when this is high.
    assign ref_take      = (state == IDLE) && ref_pending;
    assign bus.req_ready = (state == IDLE) && !ref_pending;

    // Free-running interval counter. An expiry that lands while a refresh is
    // still pending is simply absorbed; taking the refresh clears the flag
    // even if the counter expires on the same edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ref_cnt     <= REF_RELOAD;
            ref_pending <= 1'b0;
        end else begin
            if (ref_cnt == '0) begin
                ref_cnt     <= REF_RELOAD;
                ref_pending <= 1'b1;
            end else begin
                ref_cnt <= ref_cnt - 1'b1;
            end
            if (ref_take) begin
                ref_pending <= 1'b0;
            end
        end
    end
`else
    assign bus.req_ready = (state == IDLE);
`endif

    // Main FSM. Every strobe is set on the edge that enters the state in which
    // it must be valid, so all DRAM pins come straight from flops.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            cnt        <= '0;
            RAS_N      <= 1'b1;
            CAS_N      <= 1'b1;
            LWE_N      <= 1'b1;
            UWE_N      <= 1'b1;
            OE_N       <= 1'b1;
            MA         <= '0;
            data_oe    <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= 2'b00;
            wdata_q    <= '0;
            rd_valid_r <= 1'b0;
            rd_data_r  <= '0;
        end else begin
            rd_valid_r <= 1'b0;
            case (state)
                IDLE: begin
`ifdef DRAM_CTRL_REFRESH_EN
                    if (ref_pending) begin
                        // Refresh beats any waiting request.
                        state <= REF_CAS;
                        CAS_N <= 1'b0;
                    end else
`endif
                    if (bus.req_valid) begin
                        state   <= ROW;
                        MA      <= bus.req_addr;
                        RAS_N   <= 1'b0;
                        we_q    <= bus.req_we;
                        be_q    <= bus.req_be;
                        wdata_q <= bus.req_wdata;
                        data_oe <= bus.req_we;
                        cnt     <= CNT_W'(T_RCD - 1);
                    end
                end

                ROW: begin
                    if (cnt == '0) begin
                        state <= COL;
                        CAS_N <= 1'b0;
                        cnt   <= CNT_W'(T_CAS - 1);
                        if (we_q) begin
                            // be = 00 still runs the cycle, just with no lane enabled.
                            LWE_N <= ~be_q[0];
                            UWE_N <= ~be_q[1];
                        end else begin
                            OE_N <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                COL: begin
                    if (cnt == '0) begin
                        // Read data is captured on the last edge CAS is low.
                        state <= CAS_OFF;
                        CAS_N <= 1'b1;
                        if (!we_q) begin
                            rd_data_r  <= DATA;
                            rd_valid_r <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                CAS_OFF: begin
                    state   <= PRE;
                    RAS_N   <= 1'b1;
                    LWE_N   <= 1'b1;
                    UWE_N   <= 1'b1;
                    OE_N    <= 1'b1;
                    data_oe <= 1'b0;
                    cnt     <= CNT_W'(T_RP - 1);
                end

                PRE: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

`ifdef DRAM_CTRL_REFRESH_EN
                // CAS-before-RAS: CAS already low for one cycle, now drop RAS.
                REF_CAS: begin
                    state <= REF_RAS;
                    RAS_N <= 1'b0;
                    cnt   <= CNT_W'(T_CAS - 1);
                end

                REF_RAS: begin
                    if (cnt == '0) begin
                        state <= REF_OFF;
                        CAS_N <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                REF_OFF: begin
                    state <= PRE;
                    RAS_N <= 1'b1;
                    cnt   <= CNT_W'(T_RP - 1);
                end
`endif

                default: begin
                    state <= IDLE;
                    RAS_N <= 1'b1;
                    CAS_N <= 1'b1;
                    LWE_N <= 1'b1;
                    UWE_N <= 1'b1;
                    OE_N  <= 1'b1;
                    data_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule
